// File: rtl/peak_uart_tx.sv
// Sends a snapshot of the four peak-hold channels as a 6-byte 8N1 UART frame:
// 0xAA, max_1..max_4, then the 8-bit sum of the four values.
module peak_uart_tx #(
   parameter int CLKS_PER_BIT  = 434,
   parameter int PERIOD_CYCLES = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       send,
   input  logic [7:0] max_1,
   input  logic [7:0] max_2,
   input  logic [7:0] max_3,
   input  logic [7:0] max_4,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int TW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
   localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'((PERIOD_CYCLES > 0) ? PERIOD_CYCLES - 1 : 0);
   localparam logic [7:0]    HEADER     = 8'hAA;
   localparam logic [2:0]    LAST_BYTE  = 3'd5;
   localparam logic [2:0]    LAST_BIT   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   function automatic logic [7:0] frame_checksum(
      input logic [7:0] a,
      input logic [7:0] b,
      input logic [7:0] c,
      input logic [7:0] d
   );
      logic [9:0] sum;
      sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
      return sum[7:0];
   endfunction

   state_t          state_q;
   logic [TW-1:0]   timer_q;
   logic [TW-1:0]   timer_d;
   logic            timer_tc_s;
   logic            trig_s;
   logic [CW-1:0]   clk_cnt_q;
   logic [2:0]      bit_idx_q;
   logic [2:0]      byte_idx_q;
   logic [7:0]      shift_q;
   logic            pending_q;
   logic [7:0]      snap1_q;
   logic [7:0]      snap2_q;
   logic [7:0]      snap3_q;
   logic [7:0]      snap4_q;
   logic [7:0]      chk_q;
   logic [7:0]      cur_byte_s;
   logic            tx_q;
   logic            busy_q;
   logic            done_q;

   // Free-running period timer; wraps at terminal count regardless of frame activity.
   always_comb begin
      timer_tc_s = 1'b0;
      timer_d    = timer_q;
      if (PERIOD_CYCLES != 0) begin
         timer_tc_s = (timer_q == TIMER_LAST);
         if (timer_tc_s) begin
            timer_d = '0;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end else begin
         timer_d = '0;
      end
   end

   assign trig_s = send | timer_tc_s;

   // Byte currently being serialised, selected by position in the frame.
   always_comb begin
      cur_byte_s = HEADER;
      case (byte_idx_q)
         3'd0:    cur_byte_s = HEADER;
         3'd1:    cur_byte_s = snap1_q;
         3'd2:    cur_byte_s = snap2_q;
         3'd3:    cur_byte_s = snap3_q;
         3'd4:    cur_byte_s = snap4_q;
         3'd5:    cur_byte_s = chk_q;
         default: cur_byte_s = HEADER;
      endcase
   end

   // Period timer register.
   always_ff @(posedge clock) begin
      if (reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   // Frame sequencer: snapshot on accept, then START/DATA/STOP per byte.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         clk_cnt_q  <= '0;
         bit_idx_q  <= 3'd0;
         byte_idx_q <= 3'd0;
         shift_q    <= 8'h00;
         pending_q  <= 1'b0;
         snap1_q    <= 8'h00;
         snap2_q    <= 8'h00;
         snap3_q    <= 8'h00;
         snap4_q    <= 8'h00;
         chk_q      <= 8'h00;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (trig_s && (state_q != ST_IDLE)) begin
            pending_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               if (trig_s || pending_q) begin
                  snap1_q    <= max_1;
                  snap2_q    <= max_2;
                  snap3_q    <= max_3;
                  snap4_q    <= max_4;
                  chk_q      <= frame_checksum(max_1, max_2, max_3, max_4);
                  pending_q  <= 1'b0;
                  byte_idx_q <= 3'd0;
                  bit_idx_q  <= 3'd0;
                  clk_cnt_q  <= '0;
                  tx_q       <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= ST_START;
               end
            end
            ST_START: begin
               if (clk_cnt_q == BIT_LAST) begin
                  clk_cnt_q <= '0;
                  bit_idx_q <= 3'd0;
                  tx_q      <= cur_byte_s[0];
                  shift_q   <= {1'b0, cur_byte_s[7:1]};
                  state_q   <= ST_DATA;
               end else begin
                  clk_cnt_q <= clk_cnt_q + CW'(1);
               end
            end
            ST_DATA: begin
               if (clk_cnt_q == BIT_LAST) begin
                  clk_cnt_q <= '0;
                  if (bit_idx_q == LAST_BIT) begin
                     tx_q    <= 1'b1;
                     state_q <= ST_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     tx_q      <= shift_q[0];
                     shift_q   <= {1'b0, shift_q[7:1]};
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CW'(1);
               end
            end
            ST_STOP: begin
               if (clk_cnt_q == BIT_LAST) begin
                  clk_cnt_q <= '0;
                  if (byte_idx_q < LAST_BYTE) begin
                     byte_idx_q <= byte_idx_q + 3'd1;
                     tx_q       <= 1'b0;
                     state_q    <= ST_START;
                  end else begin
                     tx_q    <= 1'b1;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CW'(1);
               end
            end
            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule
